// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD frame sequencer and the serial digit converter.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } bcd_state_e;

  // Returns {err, digit}; invalid codes decode to digit 0 with err set.
  function automatic logic [BCD_DIGIT_W:0] bcd_decode(input logic [BCD_DIGIT_W-1:0] code);
    if (code > BCD_MAX_DIGIT) begin
      return {1'b1, {BCD_DIGIT_W{1'b0}}};
    end
    return {1'b0, code};
  endfunction

endpackage

// File: rtl/bcd_digit_decode.sv
// Combinational 4-bit BCD code to decimal digit decoder with invalid-code flag.
module bcd_digit_decode
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] code,
  output logic [BCD_DIGIT_W-1:0] digit,
  output logic                   err
);

  assign {err, digit} = bcd_decode(code);

endmodule

// File: rtl/bcd_frame_sequencer.sv
// Snapshots a packed BCD frame and streams it one digit per valid/ready handshake.
// Optional BCD_SKIP_INVALID_EN: invalid digits are counted and skipped instead of presented.
module bcd_frame_sequencer
  import bcd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 300,
  parameter int unsigned IDX_W      = 9
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] bcd_frame,
  output logic                          busy,
  output logic                          done,
  output logic                          dig_valid,
  input  logic                          dig_ready,
  output logic [BCD_DIGIT_W-1:0]        dig_data,
  output logic [IDX_W-1:0]              dig_index,
  output logic                          dig_err,
  output logic [IDX_W-1:0]              err_count
);

  localparam int unsigned FrameW = BCD_DIGIT_W * NUM_DIGITS;

  bcd_state_e             state_q, state_d;
  logic [FrameW-1:0]      snap_q, snap_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       err_q, err_d;
  logic [BCD_DIGIT_W-1:0] data_q, data_d;
  logic                   cur_err_q, cur_err_d;
  logic [BCD_DIGIT_W-1:0] nxt_data;
  logic                   nxt_err;
  logic                   in_run;
  logic                   skip_cyc;
  logic                   adv;

  // Snapshot shifts down one digit per advance, so the next digit is always at the bottom.
  bcd_digit_decode u_decode (
    .code  (snap_q[BCD_DIGIT_W-1:0]),
    .digit (nxt_data),
    .err   (nxt_err)
  );

  assign in_run = (state_q == StRun);

`ifdef BCD_SKIP_INVALID_EN
  assign skip_cyc  = in_run && cur_err_q;
  assign dig_valid = in_run && !cur_err_q;
  assign dig_err   = 1'b0;
`else
  assign skip_cyc  = 1'b0;
  assign dig_valid = in_run;
  assign dig_err   = in_run && cur_err_q;
`endif

  assign adv       = (dig_valid && dig_ready) || skip_cyc;
  assign busy      = (state_q == StLoad) || in_run;
  assign done      = (state_q == StDone);
  assign dig_data  = data_q;
  assign dig_index = idx_q;
  assign err_count = err_q;

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    idx_d     = idx_q;
    err_d     = err_q;
    data_d    = data_q;
    cur_err_d = cur_err_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StLoad;
            snap_d  = bcd_frame;
            idx_d   = '0;
            err_d   = '0;
          end
        end
        StLoad: begin
          data_d    = nxt_data;
          cur_err_d = nxt_err;
          snap_d    = {{BCD_DIGIT_W{1'b0}}, snap_q[FrameW-1:BCD_DIGIT_W]};
          state_d   = StRun;
        end
        StRun: begin
          if (adv) begin
            if (cur_err_q && (err_q != IDX_W'(NUM_DIGITS))) begin
              err_d = err_q + IDX_W'(1);
            end
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
              state_d = StDone;
            end else begin
              idx_d     = idx_q + IDX_W'(1);
              data_d    = nxt_data;
              cur_err_d = nxt_err;
              snap_d    = {{BCD_DIGIT_W{1'b0}}, snap_q[FrameW-1:BCD_DIGIT_W]};
            end
          end
        end
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      snap_q    <= '0;
      idx_q     <= '0;
      err_q     <= '0;
      data_q    <= '0;
      cur_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      data_q    <= data_d;
      cur_err_q <= cur_err_d;
    end
  end

endmodule

// File: tb/tb_bcd_frame_sequencer.sv
// Directed self-checking bench for bcd_frame_sequencer.
module tb_bcd_frame_sequencer;

  localparam int N = 300;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [4*N-1:0] bcd_frame = '0;
  logic           busy, done, dig_valid, dig_err;
  logic           dig_ready = 1'b0;
  logic [3:0]     dig_data;
  logic [8:0]     dig_index, err_count;

  int vectors = 0;
  int miscompares = 0;

  logic [4*N-1:0] frame_a, frame_b, frame_c, exp_frame;
  int k, hs, dones;
  bit finished;
  bit skip_mode;

  bcd_frame_sequencer #(.NUM_DIGITS(N), .IDX_W(9)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .bcd_frame (bcd_frame),
    .busy      (busy),
    .done      (done),
    .dig_valid (dig_valid),
    .dig_ready (dig_ready),
    .dig_data  (dig_data),
    .dig_index (dig_index),
    .dig_err   (dig_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] code_at(input int idx);
    logic [4*N-1:0] f;
    f = exp_frame;
    return f[4*idx +: 4];
  endfunction

  // Consume digits from the current sample point; stops on done or after stop_after handshakes.
  task automatic consume(input int mode, input int stop_after);
    bit r, pend;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (done) begin
        dones++;
        finished = 1'b1;
        break;
      end
      if (stop_after >= 0 && hs == stop_after) break;
      if (dig_valid) begin
        while (skip_mode && k < N && code_at(k) > 4'd9) k++;
        chk("dig_index", 32'(dig_index), 32'(k));
        chk("dig_data", 32'(dig_data), (code_at(k) > 4'd9) ? 32'd0 : 32'(code_at(k)));
        chk("dig_err", 32'(dig_err), 32'(code_at(k) > 4'd9));
      end
      r = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      dig_ready = r;
      pend = dig_valid && r;
      step();
      if (pend) begin
        hs++;
        k++;
      end
    end
    dig_ready = 1'b0;
    if (stop_after < 0) chk("frame_completes", 32'(finished), 32'd1);
  endtask

  task automatic begin_frame(input logic [4*N-1:0] f);
    k = 0;
    hs = 0;
    dones = 0;
    finished = 1'b0;
    exp_frame = f;
    bcd_frame = f;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_valid", 32'(dig_valid), 32'd0);
    step();
    chk("first_valid", 32'(dig_valid), 32'd1);
    chk("first_err_count", 32'(err_count), 32'd0);
  endtask

  task automatic after_done(input int exp_err);
    chk("done_pulses", 32'(dones), 32'd1);
    chk("done_err_count", 32'(err_count), 32'(exp_err));
    chk("done_valid", 32'(dig_valid), 32'd0);
    step();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("err_count_holds", 32'(err_count), 32'(exp_err));
  endtask

  initial begin
`ifdef BCD_SKIP_INVALID_EN
    skip_mode = 1'b1;
`else
    skip_mode = 1'b0;
`endif
    for (int i = 0; i < N; i++) frame_a[4*i +: 4] = 4'(i % 10);
    frame_b = frame_a;
    frame_b[4*5 +: 4] = 4'hF;
    frame_b[4*7 +: 4] = 4'hA;
    frame_b[4*299 +: 4] = 4'hC;
    for (int i = 0; i < N; i++) frame_c[4*i +: 4] = 4'h3;

    // Reset state
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(dig_valid), 32'd0);
    chk("rst_data", 32'(dig_data), 32'd0);
    chk("rst_index", 32'(dig_index), 32'd0);
    chk("rst_err", 32'(dig_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    reset = 1'b0;
    step();

    // Abort and start together in idle: abort wins
    abort = 1'b1;
    start = 1'b1;
    bcd_frame = frame_a;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_start_idle", 32'(busy), 32'd0);

    // Back-to-back streaming
    begin_frame(frame_a);
    consume(0, -1);
    chk("stream_handshakes", 32'(hs), 32'd300);
    after_done(0);

    // Stalling consumer
    begin_frame(frame_a);
    consume(1, -1);
    chk("stall_handshakes", 32'(hs), 32'd300);
    after_done(0);

    // Invalid codes at 5, 7 and 299
    begin_frame(frame_b);
    consume(0, -1);
    chk("invalid_handshakes", 32'(hs), skip_mode ? 32'd297 : 32'd300);
    after_done(3);

    // Abort after 100 handshakes keeps partial error count
    begin_frame(frame_b);
    consume(0, 100);
    chk("pre_abort_valid", 32'(dig_valid), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_valid", 32'(dig_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_err_count", 32'(err_count), 32'd2);
    step();
    chk("abort_no_done", 32'(done), 32'd0);
    begin_frame(frame_a);
    chk("restart_index", 32'(dig_index), 32'd0);
    consume(0, -1);
    after_done(0);

    // Mid-frame start and frame change are ignored
    begin_frame(frame_a);
    consume(1, 50);
    start = 1'b1;
    bcd_frame = frame_c;
    consume(1, 60);
    start = 1'b0;
    consume(0, -1);
    chk("isolated_handshakes", 32'(hs), 32'd300);
    after_done(0);

    // Asynchronous reset mid-run
    begin_frame(frame_b);
    consume(0, 20);
    #2;
    reset = 1'b1;
    #1;
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_valid", 32'(dig_valid), 32'd0);
    chk("async_index", 32'(dig_index), 32'd0);
    chk("async_data", 32'(dig_data), 32'd0);
    chk("async_err_count", 32'(err_count), 32'd0);
    step();
    reset = 1'b0;
    step();
    step();
    chk("post_reset_idle", 32'(busy), 32'd0);
    chk("post_reset_valid", 32'(dig_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_frame_sequencer.md
Name: bcd_frame_sequencer

Overview:
Sequencer that feeds the serial BCD-to-decimal digit datapath. It snapshots a 300-digit packed BCD frame on a start request and steps through it one digit at a time under a valid/ready handshake, so downstream consumers can stall. It flags invalid codes (>9) and counts them, and reports busy/done status to the frame producer. It sits between the frame source (host/register block) and the digit-consuming logic.

Parameters:
NUM_DIGITS, 300, number of 4-bit BCD digits per frame
IDX_W, 9, width of digit index and error counter; must satisfy 2**IDX_W > NUM_DIGITS

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
start  in  1  frame request; sampled only in IDLE
abort  in  1  cancel the current frame; highest priority after reset
bcd_frame  in  4*NUM_DIGITS  packed frame; digit i = bcd_frame[4*i +: 4]
busy  out  1  high in LOAD and RUN
done  out  1  one-cycle pulse after the last digit handshake
dig_valid  out  1  digit output valid
dig_ready  in  1  consumer accepts digit
dig_data  out  4  decimal digit; 0 when code invalid
dig_index  out  IDX_W  index of the presented digit
dig_err  out  1  presented digit was an invalid code (>9)
err_count  out  IDX_W  invalid digits seen in the current/last frame

Behaviour:
- Reset (async): state=IDLE. busy, done, dig_valid, dig_err = 0. dig_data=0, dig_index=0, err_count=0. Snapshot register cleared.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: start=1 -> capture bcd_frame into the snapshot, clear err_count, index=0 -> LOAD. No other action.
- LOAD: one cycle to register digit 0 onto dig_data/dig_err -> RUN. dig_valid rises on the first RUN cycle, so start-to-first-valid latency is 2 cycles.
- RUN:
  - dig_valid=1. dig_data, dig_index and dig_err hold stable while dig_ready=0 (AXI-style: valid never drops without a handshake).
  - On dig_valid&&dig_ready:
    - If the presented digit is invalid, err_count increments (at most NUM_DIGITS, no wrap).
    - If index==NUM_DIGITS-1 -> DONE and dig_valid=0.
    - Otherwise index+1 and the next digit is presented on the following cycle, giving back-to-back throughput of 1 digit/cycle.
- DONE: done=1 for exactly one cycle -> IDLE. err_count holds until the next start.
- Frame isolation: bcd_frame changes after capture have no effect on the current frame.
- start while busy or in DONE: ignored, never queued.
- abort=1 in LOAD/RUN/DONE: -> IDLE next cycle.
  - dig_valid=0 and no done pulse.
  - err_count keeps its partial value.
  - abort in IDLE has no effect; abort and start together in IDLE: abort wins, stay IDLE.
- Digit decode: code 0-9 gives dig_data=code, dig_err=0. Codes 10-15 give dig_data=0, dig_err=1.

Optional Feature:
Macro BCD_SKIP_INVALID_EN.
- Defined: invalid digits are never presented. In RUN the FSM spends one internal cycle per invalid digit with dig_valid=0, increments err_count and advances the index. dig_err is tied 0.
  - If the last digit is invalid, the FSM moves to DONE without a handshake.
  - An all-invalid frame completes with zero handshakes.
- Undefined: behaviour as above; every digit is presented, with dig_err marking invalid ones.

Decomposition:
- Shared package bcd_pkg: state enum (IDLE/LOAD/RUN/DONE), BCD_MAX_DIGIT=4'd9, BCD_DIGIT_W=4, and a function bcd_decode returning {err, digit}.
- One natural sub-module: bcd_digit_decode, combinational, 4-bit code -> {dig_err, dig_data}. It is also reusable by the existing serial converter.
- FSM, index counter, snapshot register and error counter stay in the top module.

Test Plan:
- Frame digit i = i%10, dig_ready held 1, start pulsed -> dig_valid 2 cycles after start; 300 consecutive handshakes with dig_data=i%10 and dig_index=i; done pulses once; err_count=0.
- Same frame, dig_ready toggling 1/0 every cycle -> outputs stable during stalls; 300 handshakes over ~600 cycles; data order unchanged.
- Digits 5, 7 and 299 set to 4'hF, 4'hA and 4'hC -> dig_err=1 with dig_data=0 at those indices; err_count=3 at done. With BCD_SKIP_INVALID_EN: 297 handshakes, indices 5, 7 and 299 absent, done still pulses, err_count=3.
- abort asserted after 100 handshakes -> IDLE next cycle; dig_valid=0; no done pulse. A new start then restarts at dig_index=0 with err_count cleared.
- start re-pulsed mid-frame and bcd_frame changed mid-frame -> both ignored; digits follow the captured snapshot.
- reset asserted asynchronously mid-RUN (between clock edges) -> all outputs 0 immediately; the FSM stays IDLE until the next start.
